// File: rtl/riscv_writeback_pkg.sv
// Writeback-stage shared definitions: XLEN, result-select codes, counter width.
// Optional retired-instruction counter is enabled by RISCV_WB_INSTRET_EN.
`ifndef XLEN
`define XLEN 32
`endif

package riscv_writeback_pkg;

    localparam int XLEN      = `XLEN;
    localparam int INSTRET_W = 64;

    localparam logic [1:0] RESULT_SRC_ALU = 2'b00;
    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;
    localparam logic [1:0] RESULT_SRC_PC4 = 2'b10;

    // The reserved code falls back to the ALU value so no X reaches the RF.
    function automatic logic [XLEN-1:0] wb_select(
        input logic [1:0]      src,
        input logic [XLEN-1:0] alu,
        input logic [XLEN-1:0] rdata,
        input logic [XLEN-1:0] pc4
    );
        logic [XLEN-1:0] res;
        case (src)
            RESULT_SRC_MEM: res = rdata;
            RESULT_SRC_PC4: res = pc4;
            default:        res = alu;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/riscv_wb_instret.sv
// Wrapping retired-instruction counter with a single increment enable.
// Only instantiated when RISCV_WB_INSTRET_EN is defined.
module riscv_wb_instret
    import riscv_writeback_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 inc_i,
    output logic [INSTRET_W-1:0] count_o
);

    logic [INSTRET_W-1:0] count_q;
    logic [INSTRET_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i) begin
            count_d = count_q + INSTRET_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/riscv_writeback.sv
// RV32I writeback stage: MEM/WB register, result select, RF write port.
// Define RISCV_WB_INSTRET_EN to build the 64-bit retired-instruction counter.
`ifndef XLEN
`define XLEN 32
`endif

module riscv_writeback
    import riscv_writeback_pkg::*;
#(
    parameter int               RF_ADDR_W = 5,
    parameter logic [`XLEN-1:0] RESET_PC4 = 32'h0000_0000
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_stall_w,
    input  logic                 i_flush_w,
    input  logic                 i_valid_m,
    input  logic                 i_reg_write_m,
    input  logic [1:0]           i_result_src_m,
    input  logic [RF_ADDR_W-1:0] i_rd_m,
    input  logic [`XLEN-1:0]     i_alu_result_m,
    input  logic [`XLEN-1:0]     i_read_data_m,
    input  logic [`XLEN-1:0]     i_pc_plus4_m,
    output logic [`XLEN-1:0]     o_result_w,
    output logic [RF_ADDR_W-1:0] o_rd_w,
    output logic                 o_reg_write_w,
    output logic                 o_valid_w,
    output logic [63:0]          o_instret
);

    logic                 valid_q, valid_d;
    logic                 reg_write_q, reg_write_d;
    logic [1:0]           src_q, src_d;
    logic [RF_ADDR_W-1:0] rd_q, rd_d;
    logic [`XLEN-1:0]     alu_q, alu_d;
    logic [`XLEN-1:0]     rdata_q, rdata_d;
    logic [`XLEN-1:0]     pc4_q, pc4_d;

    // Flush takes M data fields too; only valid/reg_write matter after it.
    always_comb begin
        valid_d     = valid_q;
        reg_write_d = reg_write_q;
        src_d       = src_q;
        rd_d        = rd_q;
        alu_d       = alu_q;
        rdata_d     = rdata_q;
        pc4_d       = pc4_q;
        if (i_flush_w || !i_stall_w) begin
            src_d   = i_result_src_m;
            rd_d    = i_rd_m;
            alu_d   = i_alu_result_m;
            rdata_d = i_read_data_m;
            pc4_d   = i_pc_plus4_m;
        end
        if (i_flush_w) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
        end else if (!i_stall_w) begin
            valid_d     = i_valid_m;
            reg_write_d = i_reg_write_m & i_valid_m;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            src_q       <= RESULT_SRC_ALU;
            rd_q        <= '0;
            alu_q       <= '0;
            rdata_q     <= '0;
            pc4_q       <= RESET_PC4;
        end else begin
            valid_q     <= valid_d;
            reg_write_q <= reg_write_d;
            src_q       <= src_d;
            rd_q        <= rd_d;
            alu_q       <= alu_d;
            rdata_q     <= rdata_d;
            pc4_q       <= pc4_d;
        end
    end

    assign o_result_w    = wb_select(src_q, alu_q, rdata_q, pc4_q);
    assign o_rd_w        = rd_q;
    assign o_valid_w     = valid_q;
    assign o_reg_write_w = reg_write_q & valid_q & (rd_q != '0);

`ifdef RISCV_WB_INSTRET_EN
    logic retire;

    assign retire = i_valid_m & ~i_flush_w & ~i_stall_w;

    riscv_wb_instret u_instret (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .inc_i   (retire),
        .count_o (o_instret)
    );
`else
    assign o_instret = 64'h0;
`endif

endmodule

// File: tb/tb_riscv_writeback.sv
// Self-checking bench for riscv_writeback against a behavioural W-stage model.
// Honours RISCV_WB_INSTRET_EN for the expected counter behaviour.
module tb_riscv_writeback;

    logic        clk;
    logic        rst;
    logic        stall, flush, valid_m, rw_m;
    logic [1:0]  src_m;
    logic [4:0]  rd_m;
    logic [31:0] alu_m, rdata_m, pc4_m;
    logic [31:0] o_result_w;
    logic [4:0]  o_rd_w;
    logic        o_reg_write_w, o_valid_w;
    logic [63:0] o_instret;

    int n_cmp  = 0;
    int n_fail = 0;
    bit check_en = 0;
    bit ld_cnt   = 0;

    riscv_writeback dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_stall_w      (stall),
        .i_flush_w      (flush),
        .i_valid_m      (valid_m),
        .i_reg_write_m  (rw_m),
        .i_result_src_m (src_m),
        .i_rd_m         (rd_m),
        .i_alu_result_m (alu_m),
        .i_read_data_m  (rdata_m),
        .i_pc_plus4_m   (pc4_m),
        .o_result_w     (o_result_w),
        .o_rd_w         (o_rd_w),
        .o_reg_write_w  (o_reg_write_w),
        .o_valid_w      (o_valid_w),
        .o_instret      (o_instret)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Model: what W must hold after each edge, from the stage's rules.
    logic        m_valid, m_rw;
    logic [1:0]  m_src;
    logic [4:0]  m_rd;
    logic [31:0] m_alu, m_rdata, m_pc4;
    logic [63:0] m_instret;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid   <= 0;
            m_rw      <= 0;
            m_src     <= 0;
            m_rd      <= 0;
            m_alu     <= 0;
            m_rdata   <= 0;
            m_pc4     <= 0;
            m_instret <= 0;
        end else begin
            if (flush) begin
                m_valid <= 0;
                m_rw    <= 0;
            end else if (!stall) begin
                m_valid <= valid_m;
                m_rw    <= rw_m && valid_m;
                m_src   <= src_m;
                m_rd    <= rd_m;
                m_alu   <= alu_m;
                m_rdata <= rdata_m;
                m_pc4   <= pc4_m;
            end
`ifdef RISCV_WB_INSTRET_EN
            if (ld_cnt)
                m_instret <= 64'hFFFF_FFFF_FFFF_FFFF;
            else if (valid_m && !flush && !stall)
                m_instret <= m_instret + 1;
`endif
        end
    end

    function automatic logic [31:0] exp_result();
        if (m_src == 2'd1) return m_rdata;
        if (m_src == 2'd2) return m_pc4;
        return m_alu;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("valid", 64'(o_valid_w), 64'(m_valid));
            chk("we", 64'(o_reg_write_w), 64'(m_rw && m_valid && m_rd != 0));
            chk("instret", o_instret, m_instret);
            if (m_valid) begin
                chk("result", 64'(o_result_w), 64'(exp_result()));
                chk("rd", 64'(o_rd_w), 64'(m_rd));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic rw, input logic [1:0] s,
                       input logic [4:0] rd, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] p);
        valid_m = v; rw_m = rw; src_m = s; rd_m = rd;
        alu_m = a; rdata_m = d; pc4_m = p;
    endtask

    task automatic drv_rand();
        drv(1'($urandom), 1'($urandom), 2'($urandom),
            ($urandom % 4 == 0) ? 5'd0 : 5'($urandom),
            $urandom, $urandom, $urandom);
    endtask

    logic [63:0] base_cnt;
    logic [63:0] exp10;

    initial begin
        rst = 1; stall = 0; flush = 0;
        drv(0, 0, 0, 0, 0, 0, 0);
        #12;
        rst = 0;
        check_en = 1;
        tick();
        chk("rst_valid", 64'(o_valid_w), 64'd0);
        chk("rst_instret", o_instret, 64'd0);

        // Result select over all four codes.
        for (int s = 0; s < 4; s++) begin
            drv(1, 1, 2'(s), 5'd5, 32'h1234, 32'hDEAD_BEEF, 32'h104);
            tick();
            chk("we_sel", 64'(o_reg_write_w), 64'd1);
            case (s)
                0: chk("sel_alu", 64'(o_result_w), 64'h1234);
                1: chk("sel_mem", 64'(o_result_w), 64'hDEAD_BEEF);
                2: chk("sel_pc4", 64'(o_result_w), 64'h104);
                default: chk("sel_rsv", 64'(o_result_w), 64'h1234);
            endcase
        end

        // Write to x0 is never enabled.
        drv(1, 1, 0, 5'd0, 32'h77, 0, 0);
        tick();
        chk("x0_we", 64'(o_reg_write_w), 64'd0);
        chk("x0_rd", 64'(o_rd_w), 64'd0);
        chk("x0_valid", 64'(o_valid_w), 64'd1);

        // Stall holds W and counts once; flush under stall squashes.
        drv(1, 1, 0, 5'd7, 32'h55, 32'h66, 32'h88);
        tick();
        base_cnt = o_instret;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            drv_rand();
            tick();
            chk("stall_res", 64'(o_result_w), 64'h55);
            chk("stall_rd", 64'(o_rd_w), 64'd7);
            chk("stall_cnt", o_instret, base_cnt);
        end
        flush = 1;
        tick();
        chk("flush_valid", 64'(o_valid_w), 64'd0);
        chk("flush_we", 64'(o_reg_write_w), 64'd0);
        stall = 0; flush = 0;

        // Async reset mid-cycle with data present.
        drv(1, 1, 1, 5'd3, 32'hAA, 32'hBB, 32'hCC);
        tick();
        #2 rst = 1;
        #1;
        chk("arst_res", 64'(o_result_w), 64'd0);
        chk("arst_we", 64'(o_reg_write_w), 64'd0);
        chk("arst_valid", 64'(o_valid_w), 64'd0);
        chk("arst_rd", 64'(o_rd_w), 64'd0);
        chk("arst_cnt", o_instret, 64'd0);
        tick();
        #2 rst = 0;

        // Ten retires with two bubbles.
        for (int i = 0; i < 12; i++) begin
            if (i == 3 || i == 8) drv(0, 1, 0, 5'd9, i, 0, 0);
            else drv(1, 1, 0, 5'(i + 1), i, 0, 0);
            tick();
        end
`ifdef RISCV_WB_INSTRET_EN
        exp10 = 64'd10;
`else
        exp10 = 64'd0;
`endif
        chk("cnt10", o_instret, exp10);

`ifdef RISCV_WB_INSTRET_EN
        check_en = 0;
        drv(0, 0, 0, 0, 0, 0, 0);
        force dut.u_instret.count_q = 64'hFFFF_FFFF_FFFF_FFFF;
        ld_cnt = 1;
        tick();
        release dut.u_instret.count_q;
        ld_cnt = 0;
        tick();
        check_en = 1;
        drv(1, 1, 0, 5'd1, 0, 0, 0);
        tick();
        chk("cnt_wrap", o_instret, 64'd0);
`endif

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            stall = ($urandom % 5 == 0);
            flush = ($urandom % 10 == 0);
            drv_rand();
            tick();
        end
        stall = 0; flush = 0;
        tick();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_writeback.md
Name: riscv_writeback

Overview:
- Writeback stage of the 5-stage RV32I pipeline, directly downstream of the memory stage.
- Registers the M-stage results into a MEM/WB pipeline register with stall and flush controls.
- Selects the final writeback value (ALU result, load data, PC+4) and drives the register-file write port and the W-stage forwarding source.
- Optionally keeps a retired-instruction counter.

Parameters:
- RF_ADDR_W, 5, register-file index width.
- RESET_PC4, 32'h0000_0000, reset value of the captured PC+4 field; reset visibility only.

Ports:
- i_clk  input  1  core clock, rising edge.
- i_rst  input  1  asynchronous active-high reset.
- i_stall_w  input  1  hold the MEM/WB register.
- i_flush_w  input  1  squash the instruction entering W.
- i_valid_m  input  1  M stage holds a real instruction.
- i_reg_write_m  input  1  instruction writes rd.
- i_result_src_m  input  2  result select: 00 ALU, 01 memory, 10 PC+4, 11 reserved.
- i_rd_m  input  RF_ADDR_W  destination register.
- i_alu_result_m  input  `XLEN  ALU result from M.
- i_read_data_m  input  `XLEN  load data from the memory stage, already byte-aligned and extended, combinational in M.
- i_pc_plus4_m  input  `XLEN  link value for JAL/JALR.
- o_result_w  output  `XLEN  writeback value.
- o_rd_w  output  RF_ADDR_W  register-file write index.
- o_reg_write_w  output  1  register-file write enable.
- o_valid_w  output  1  W holds a real instruction.
- o_instret  output  64  retired-instruction count.

Behaviour:
- Reset state: all MEM/WB fields clear asynchronously on i_rst=1.
  - valid=0, reg_write=0, rd=0, result_src=00, alu=0, rdata=0.
  - pc4=RESET_PC4, instret=0.
  - Outputs during reset: o_result_w=0, o_reg_write_w=0, o_valid_w=0, o_rd_w=0, o_instret=0.
- Update priority on each rising edge: reset > flush > stall > capture.
- Flush: valid and reg_write go to 0. Data fields may take the M values and are don't-care.
- Stall: every field holds, including valid. Flush during stall still squashes.
- Capture: all fields load from M. valid <= i_valid_m; reg_write <= i_reg_write_m & i_valid_m.
- Latency: exactly 1 cycle from M inputs to W outputs.
- o_result_w is combinational from the registered fields:
  - 00 -> alu.
  - 01 -> rdata.
  - 10 -> pc4.
  - 11 -> alu (reserved code; no X is propagated).
- o_reg_write_w = reg_write & valid & (rd != 0). Writes to x0 never assert the enable.
- o_rd_w is the registered rd, unmasked. Hazard logic qualifies it with o_reg_write_w.
- o_valid_w is the registered valid.
- Retire event: a capture edge with i_valid_m=1, no flush, no stall.
- o_instret increments by 1 on each retire event and wraps from 2^64-1 to 0.
- A stalled W instruction is counted once only, at its capture edge.
- Reset asserted mid-stall or mid-flush: the state clears immediately. The first capture after i_rst deasserts behaves normally.
- i_result_src_m is ignored when i_valid_m=0, because the enable is already masked.

Optional Feature:
- Macro: RISCV_WB_INSTRET_EN.
- Defined: the 64-bit counter is built and behaves as described above.
- Undefined: no counter flops are built and o_instret is tied to 64'h0. All other behaviour is identical.

Decomposition:
- Shared defines header (alongside the existing common core defines) holds:
  - `XLEN.
  - RESULT_SRC_ALU=2'b00, RESULT_SRC_MEM=2'b01, RESULT_SRC_PC4=2'b10.
  - INSTRET_W=64.
- One sub-module: riscv_wb_instret, the wrapping counter with an increment enable.
  - Instantiated only under RISCV_WB_INSTRET_EN.

Test Plan:
- Reset: assert i_rst asynchronously mid-cycle with captured data present -> all outputs read 0 before the next edge, o_instret=0.
- Result select: capture valid, reg_write=1, rd=5, alu=32'h1234, rdata=32'hDEAD_BEEF, pc4=32'h104 with src=00/01/10/11 on successive cycles.
  - Required o_result_w: 0x1234, 0xDEADBEEF, 0x104, 0x1234.
  - o_reg_write_w=1 for each.
- x0 suppression: rd=0, reg_write=1, valid=1 -> o_reg_write_w=0, o_rd_w=0, o_valid_w=1.
- Stall/flush:
  - Capture an instruction, then stall 3 cycles while M inputs change -> W outputs unchanged, o_instret up by 1 only.
  - Then flush with stall=1 -> o_valid_w=0, o_reg_write_w=0.
- Counter: drive 10 valid captures with 2 bubbles (i_valid_m=0) interleaved -> o_instret=10.
  - Force the counter to 64'hFFFF_FFFF_FFFF_FFFF, retire one -> o_instret=0.
  - With the macro undefined -> o_instret stays 0 throughout.
